imem_loadable: RTL and testbench
================================

Name: imem_loadable

Overview:
- Parametrised successor to the fixed 64x32 instruction ROM.
- Synchronous-read instruction memory; depth, width and read latency set by parameters.
- Zeroed by a hardware clear sweep after reset; programmed at run time through a streaming load port, not from a static initialiser.
- The fetch side uses a valid/ready request and a valid response, so the core or testbench can stall while a program is loaded.

Parameters:
- N, 32, instruction word width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, fetch latency in cycles from accepted request to rsp_valid; legal values 1 or 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_start  in  1  begin a new program load at address 0.
- ld_valid  in  1  ld_data is a word to store this cycle.
- ld_last  in  1  qualifies ld_valid; marks the final word of the program.
- ld_data  in  N  program word.
- ld_busy  out  1  high while in LOAD state.
- ld_err  out  1  sticky overflow flag for the current or last load.
- ld_count  out  ADDR_W+1  words stored by the current or last load; saturates at DEPTH.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  word address to fetch.
- rsp_valid  out  1  rsp_data valid this cycle.
- rsp_data  out  N  fetched word.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- State machine: states CLEAR, READY, LOAD.
- Reset values: state=CLEAR, clr_ptr=0, wr_ptr=0, req_ready=0, rsp_valid=0 (all pipeline stages), rsp_data=0, ld_busy=0, ld_err=0, ld_count=0.
- Reset mid-operation: reset in any state (including mid-LOAD or with responses in flight) aborts everything and re-enters CLEAR.
- CLEAR:
  - Writes 0 to mem[clr_ptr] each cycle and increments clr_ptr.
  - After writing DEPTH-1, goes to READY, so the sweep takes exactly DEPTH cycles after reset deasserts.
  - ld_start and req_valid are ignored in CLEAR.
- READY:
  - req_ready = 1 && !ld_start; this is the only combinational input-to-output path.
  - On accept, mem[req_addr] is read on that edge; rsp_valid/rsp_data appear RD_LAT cycles later.
  - One request may be accepted per cycle with no bubbles; throughput is 1 word per cycle.
  - No back-pressure on the response side.
  - rsp_data holds its last value while rsp_valid=0.
- Entering LOAD: ld_start in READY moves to LOAD next cycle and, on the same edge, clears wr_ptr, ld_count and ld_err.
- LOAD:
  - ld_busy=1 and req_ready=0.
  - Responses already in flight still complete on schedule and carry pre-load contents.
  - On each ld_valid: if wr_ptr<DEPTH, write mem[wr_ptr]=ld_data, increment wr_ptr and ld_count; otherwise drop the word and set ld_err=1.
  - Cycles with ld_valid=0 have no effect.
  - ld_valid && ld_last returns to READY next cycle; the last word is written if in range.
  - ld_start in LOAD is ignored.
  - ld_last without ld_valid is ignored.
- ld_count width: ADDR_W+1, so DEPTH is representable; it never wraps.
- Untouched words: a load that writes fewer than DEPTH words leaves higher words unchanged (zero after reset, or previous program contents).
- No read-during-write hazard is possible: fetch is blocked during LOAD, and CLEAR writes while no requests are accepted.

Test Plan:
- Reset sweep (ADDR_W=6): assert reset 2 cycles -> req_ready stays 0 for 64 cycles after release, then 1. Request addr 5 -> rsp_valid after RD_LAT with rsp_data=32'h0.
- Load and readback (RD_LAT=1 and 2): ld_start, then f8000000, f8008001, f8010002, d61f0300 with ld_last on the 4th -> ld_count=4, ld_busy falls. Back-to-back requests for addr 0..3 return the same words on 4 consecutive cycles.
- Bubbled load: ld_valid pattern 1,0,0,1,0,1(ld_last) -> exactly 3 words stored at addrs 0..2 and ld_count=3. ld_last asserted with ld_valid=0 earlier must not end the load.
- Overflow (ADDR_W=2): load 6 words with ld_last on the 6th -> addrs 0..3 hold words 1..4, ld_count=4, ld_err=1. The next ld_start clears ld_err to 0.
- Boundary with ld_start:
  - Request addr 0 in the same cycle as ld_start -> not accepted (req_ready=0).
  - A request accepted 1 cycle before ld_start -> returns the old word during LOAD.
  - req_ready stays 0 until the cycle after the ld_last word.
- Reset mid-load: after 3 of 5 words, assert reset -> ld_busy=0, ld_count=0, 64-cycle CLEAR. Reads of addrs 0..2 then return 0.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory.
// A hardware sweep zeroes every word after reset. A streaming port then loads
// a program at run time. Fetches use a valid/ready request and a fixed-latency
// response with no back-pressure.
module imem_loadable #(
  parameter int N      = 32,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [N-1:0]      ld_data,
  output logic              ld_busy,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_count,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [N-1:0]      rsp_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [ADDR_W:0]   wr_ptr_r;
  logic [N-1:0]      mem_r [DEPTH];

  logic              accept_s;
  logic              ld_write_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [N-1:0]      wdata_s;

  logic              s1_valid_r;
  logic [N-1:0]      s1_data_r;

  // Fetch handshake: ld_start wins over a fetch in the same cycle.
  always_comb begin
    req_ready = 1'b0;
    if (state_r == ST_READY) begin
      req_ready = !ld_start;
    end else begin
      req_ready = 1'b0;
    end
  end

  assign accept_s   = req_valid && req_ready;
  // wr_ptr never exceeds DEPTH, so its MSB alone flags "memory full".
  assign ld_write_s = (state_r == ST_LOAD) && ld_valid && !wr_ptr_r[ADDR_W];

  // Single write port: the clear sweep or a load word, never both.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = '0;
    wdata_s = '0;
    if (reset) begin
      we_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      we_s    = 1'b1;
      waddr_s = clr_ptr_r;
      wdata_s = '0;
    end else if (ld_write_s) begin
      we_s    = 1'b1;
      waddr_s = wr_ptr_r[ADDR_W-1:0];
      wdata_s = ld_data;
    end else begin
      we_s = 1'b0;
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // First read stage: sample the array on the accepting edge; the data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= mem_r[req_addr];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      // Second read stage; rsp_data keeps its last value while idle.
      always_ff @(posedge clk) begin
        if (reset) begin
          rsp_valid <= 1'b0;
          rsp_data  <= '0;
        end else begin
          rsp_valid <= s1_valid_r;
          if (s1_valid_r) begin
            rsp_data <= s1_data_r;
          end
        end
      end
    end else begin : g_lat1
      assign rsp_valid = s1_valid_r;
      assign rsp_data  = s1_data_r;
    end
  endgenerate

  // Control FSM: clear sweep, idle/fetch, program load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_ptr_r <= '0;
      wr_ptr_r  <= '0;
      ld_busy   <= 1'b0;
      ld_err    <= 1'b0;
      ld_count  <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + PTR_ONE;
          if (clr_ptr_r == PTR_LAST) begin
            state_r <= ST_READY;
          end
        end
        ST_READY: begin
          if (ld_start) begin
            state_r  <= ST_LOAD;
            wr_ptr_r <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
            ld_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            if (!wr_ptr_r[ADDR_W]) begin
              wr_ptr_r <= wr_ptr_r + CNT_ONE;
              ld_count <= ld_count + CNT_ONE;
            end else begin
              ld_err <= 1'b1;
            end
            if (ld_last) begin
              state_r <= ST_READY;
              ld_busy <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          ld_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable. Three instances share one stimulus:
// a: ADDR_W=6, RD_LAT=1; b: ADDR_W=6, RD_LAT=2; c: ADDR_W=2, RD_LAT=1.
module tb_imem_loadable;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ld_start, ld_valid, ld_last, req_valid;
  logic [31:0] ld_data;
  logic [5:0]  req_addr;

  logic        a_ld_busy, a_ld_err, a_req_ready, a_rsp_valid;
  logic [6:0]  a_ld_count;
  logic [31:0] a_rsp_data;
  logic        b_ld_busy, b_ld_err, b_req_ready, b_rsp_valid;
  logic [6:0]  b_ld_count;
  logic [31:0] b_rsp_data;
  logic        c_ld_busy, c_ld_err, c_req_ready, c_rsp_valid;
  logic [2:0]  c_ld_count;
  logic [31:0] c_rsp_data;

  imem_loadable #(.N(32), .ADDR_W(6), .RD_LAT(1)) u_a (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_data(ld_data), .ld_busy(a_ld_busy), .ld_err(a_ld_err),
    .ld_count(a_ld_count), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_addr(req_addr), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data));

  imem_loadable #(.N(32), .ADDR_W(6), .RD_LAT(2)) u_b (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_data(ld_data), .ld_busy(b_ld_busy), .ld_err(b_ld_err),
    .ld_count(b_ld_count), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_addr(req_addr), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data));

  imem_loadable #(.N(32), .ADDR_W(2), .RD_LAT(1)) u_c (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_data(ld_data), .ld_busy(c_ld_busy), .ld_err(c_ld_err),
    .ld_count(c_ld_count), .req_valid(req_valid), .req_ready(c_req_ready),
    .req_addr(req_addr[1:0]), .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data));

  typedef struct {
    logic        lv;
    logic        ll;
    logic [31:0] d;
    logic [6:0]  a_cnt;
    logic        a_busy;
    logic [2:0]  c_cnt;
    logic        c_err;
  } ld_vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  ld_vec_t ld_tab [0:20];
  rd_vec_t rd_tab [0:16];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (a_req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    #1;
    chk("ready_with_start", a_req_ready, 32'd0);
    tick();
    ld_start = 1'b0;
    chk("busy_after_start", a_ld_busy, 32'd1);
  endtask

  task automatic run_load(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ld_valid = ld_tab[i].lv;
      ld_last  = ld_tab[i].ll;
      ld_data  = ld_tab[i].d;
      #1;
      chk("ready_in_load", a_req_ready, 32'd0);
      tick();
      chk("a_ld_count", a_ld_count, ld_tab[i].a_cnt);
      chk("a_ld_busy", a_ld_busy, ld_tab[i].a_busy);
      chk("a_ld_err", a_ld_err, 32'd0);
      chk("c_ld_count", c_ld_count, ld_tab[i].c_cnt);
      chk("c_ld_err", c_ld_err, ld_tab[i].c_err);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic readback(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req_valid = 1'b1;
      req_addr  = rd_tab[i].addr;
      tick();
      chk("a_rsp_valid", a_rsp_valid, 32'd1);
      chk("a_rsp_data", a_rsp_data, rd_tab[i].exp);
      chk("c_rsp_data", c_rsp_data, rd_tab[i].exp);
      if (i == lo) begin
        chk("b_rsp_valid_lat", b_rsp_valid, 32'd0);
      end else begin
        chk("b_rsp_valid", b_rsp_valid, 32'd1);
        chk("b_rsp_data", b_rsp_data, rd_tab[i-1].exp);
      end
    end
    req_valid = 1'b0;
    tick();
    chk("b_rsp_valid_tail", b_rsp_valid, 32'd1);
    chk("b_rsp_data_tail", b_rsp_data, rd_tab[hi].exp);
    chk("a_rsp_valid_idle", a_rsp_valid, 32'd0);
    chk("a_rsp_data_hold", a_rsp_data, rd_tab[hi].exp);
  endtask

  initial begin
    int n;
    // load vectors: lv, ll, data, a_cnt, a_busy, c_cnt, c_err
    ld_tab[0]  = '{1'b1, 1'b0, 32'hf8000000, 7'd1, 1'b1, 3'd1, 1'b0};
    ld_tab[1]  = '{1'b1, 1'b0, 32'hf8008001, 7'd2, 1'b1, 3'd2, 1'b0};
    ld_tab[2]  = '{1'b1, 1'b0, 32'hf8010002, 7'd3, 1'b1, 3'd3, 1'b0};
    ld_tab[3]  = '{1'b1, 1'b1, 32'hd61f0300, 7'd4, 1'b0, 3'd4, 1'b0};
    ld_tab[4]  = '{1'b1, 1'b0, 32'ha0000001, 7'd1, 1'b1, 3'd1, 1'b0};
    ld_tab[5]  = '{1'b0, 1'b1, 32'hdeaddead, 7'd1, 1'b1, 3'd1, 1'b0};
    ld_tab[6]  = '{1'b0, 1'b0, 32'hdeaddead, 7'd1, 1'b1, 3'd1, 1'b0};
    ld_tab[7]  = '{1'b1, 1'b0, 32'ha0000002, 7'd2, 1'b1, 3'd2, 1'b0};
    ld_tab[8]  = '{1'b0, 1'b0, 32'hdeaddead, 7'd2, 1'b1, 3'd2, 1'b0};
    ld_tab[9]  = '{1'b1, 1'b1, 32'ha0000003, 7'd3, 1'b0, 3'd3, 1'b0};
    ld_tab[10] = '{1'b1, 1'b0, 32'h11111111, 7'd1, 1'b1, 3'd1, 1'b0};
    ld_tab[11] = '{1'b1, 1'b0, 32'h22222222, 7'd2, 1'b1, 3'd2, 1'b0};
    ld_tab[12] = '{1'b1, 1'b0, 32'h33333333, 7'd3, 1'b1, 3'd3, 1'b0};
    ld_tab[13] = '{1'b1, 1'b0, 32'h44444444, 7'd4, 1'b1, 3'd4, 1'b0};
    ld_tab[14] = '{1'b1, 1'b0, 32'h55555555, 7'd5, 1'b1, 3'd4, 1'b1};
    ld_tab[15] = '{1'b1, 1'b1, 32'h66666666, 7'd6, 1'b0, 3'd4, 1'b1};
    ld_tab[16] = '{1'b1, 1'b0, 32'hcafe0001, 7'd1, 1'b1, 3'd1, 1'b0};
    ld_tab[17] = '{1'b1, 1'b1, 32'hcafe0002, 7'd2, 1'b0, 3'd2, 1'b0};
    ld_tab[18] = '{1'b1, 1'b0, 32'hbeef0001, 7'd1, 1'b1, 3'd1, 1'b0};
    ld_tab[19] = '{1'b1, 1'b0, 32'hbeef0002, 7'd2, 1'b1, 3'd2, 1'b0};
    ld_tab[20] = '{1'b1, 1'b0, 32'hbeef0003, 7'd3, 1'b1, 3'd3, 1'b0};
    // readback vectors: addr, expected word
    rd_tab[0]  = '{6'd5, 32'h00000000};
    rd_tab[1]  = '{6'd0, 32'hf8000000};
    rd_tab[2]  = '{6'd1, 32'hf8008001};
    rd_tab[3]  = '{6'd2, 32'hf8010002};
    rd_tab[4]  = '{6'd3, 32'hd61f0300};
    rd_tab[5]  = '{6'd0, 32'ha0000001};
    rd_tab[6]  = '{6'd1, 32'ha0000002};
    rd_tab[7]  = '{6'd2, 32'ha0000003};
    rd_tab[8]  = '{6'd3, 32'hd61f0300};
    rd_tab[9]  = '{6'd0, 32'h11111111};
    rd_tab[10] = '{6'd1, 32'h22222222};
    rd_tab[11] = '{6'd2, 32'h33333333};
    rd_tab[12] = '{6'd3, 32'h44444444};
    rd_tab[13] = '{6'd0, 32'h00000000};
    rd_tab[14] = '{6'd1, 32'h00000000};
    rd_tab[15] = '{6'd2, 32'h00000000};
    rd_tab[16] = '{6'd3, 32'h00000000};

    reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = 32'd0; req_valid = 1'b0; req_addr = 6'd0;

    // reset values and clear sweep length
    tick();
    tick();
    chk("rst_req_ready", a_req_ready, 32'd0);
    chk("rst_rsp_valid", a_rsp_valid, 32'd0);
    chk("rst_b_rsp_valid", b_rsp_valid, 32'd0);
    chk("rst_rsp_data", a_rsp_data, 32'd0);
    chk("rst_ld_busy", a_ld_busy, 32'd0);
    chk("rst_ld_err", a_ld_err, 32'd0);
    chk("rst_ld_count", a_ld_count, 32'd0);
    reset = 1'b0;
    wait_ready(n);
    chk("sweep_cycles", n, 32'd64);
    readback(0, 0);

    // plain program load and back-to-back readback
    start_load();
    run_load(0, 3);
    chk("ready_after_last", a_req_ready, 32'd1);
    readback(1, 4);

    // bubbled load with a stray ld_last; addr 3 keeps the old word
    start_load();
    run_load(4, 9);
    readback(5, 8);

    // overflow on the 4-word instance
    start_load();
    run_load(10, 15);
    readback(9, 12);

    // ld_start boundary: in-flight fetch returns pre-load data
    req_valid = 1'b1;
    req_addr  = 6'd0;
    #1;
    chk("ready_before_start", a_req_ready, 32'd1);
    tick();
    ld_start = 1'b1;
    req_addr = 6'd1;
    #1;
    chk("ready_with_start", a_req_ready, 32'd0);
    chk("a_old_word", a_rsp_data, 32'h11111111);
    tick();
    ld_start = 1'b0;
    req_addr = 6'd0;
    chk("busy_after_start", a_ld_busy, 32'd1);
    chk("inflight_valid", b_rsp_valid, 32'd1);
    chk("inflight_old", b_rsp_data, 32'h11111111);
    chk("start_req_dropped", a_rsp_valid, 32'd0);
    chk("err_cleared", c_ld_err, 32'd0);
    chk("count_cleared", c_ld_count, 32'd0);
    run_load(16, 17);
    chk("ready_after_last", a_req_ready, 32'd1);
    tick();
    chk("new_word_valid", a_rsp_valid, 32'd1);
    chk("new_word", a_rsp_data, 32'hcafe0001);
    req_valid = 1'b0;
    tick();

    // reset in the middle of a load
    start_load();
    run_load(18, 20);
    reset = 1'b1;
    tick();
    chk("midrst_busy", a_ld_busy, 32'd0);
    chk("midrst_count", a_ld_count, 32'd0);
    chk("midrst_ready", a_req_ready, 32'd0);
    chk("midrst_rsp_valid", a_rsp_valid, 32'd0);
    reset = 1'b0;
    wait_ready(n);
    chk("midrst_sweep_cycles", n, 32'd64);
    readback(13, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
